imem_loader: RTL and testbench

Program loader for the 10-bit instruction memory: the writing end of the instruction-fetch interface. It accepts a stream of 10-bit instruction words over a valid/ready handshake and writes them to consecutive instruction-memory addresses starting at 0. Loading ends at the halt word. It then reads the loaded image back over the same combinational-read port and checks it against a running XOR checksum. Only after a clean verify does it release the CPU via `cpu_run`.

---
 rtl/imem_loader.sv | 169 ++++++++++++++++
 tb/tb_imem_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writing end of the instruction-fetch interface.
//
// Accepts a stream of instruction words, writes them to consecutive
// instruction-memory addresses from 0, and stops at HALT_WORD. It then reads
// the image back and compares a running XOR checksum against the one taken
// while loading. The CPU is released via cpu_run only after a clean verify.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   start               begin a load (honoured in IDLE/DONE/ERROR only)
//   in_valid/in_data    incoming instruction stream
//   in_ready            loader can take a word this cycle (combinational)
//   mem_we/mem_addr/
//   mem_wdata           instruction-memory write port (combinational)
//   mem_rdata           combinational read data for mem_addr
//   busy/done/error     registered status (LOAD or VERIFY / DONE / ERROR)
//   err_code            0 none, 1 overflow, 2 verify mismatch
//   word_count          words written in current/last load, halt included
//   cpu_run             CPU may fetch; mirrors done
//   dbg_state           current FSM state for observation
//
// Handshake: a word transfers on every rising edge where in_valid and
// in_ready are both high; in_ready does not depend on in_valid, and the
// source must hold in_data stable while in_valid is high and in_ready low.
module imem_loader #(
    parameter int                 ADDR_W    = 10,
    parameter int                 DATA_W    = 10,
    parameter logic [DATA_W-1:0]  HALT_WORD = 10'b0010000010
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count,
    output logic              cpu_run,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_VERIFY = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] WR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WC_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] WR_MAX = {ADDR_W{1'b1}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic [DATA_W-1:0]   load_sum_q, load_sum_d;
    logic [DATA_W-1:0]   ver_sum_q, ver_sum_d;
    logic [1:0]          err_code_q, err_code_d;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        word_count_d = word_count_q;
        load_sum_d   = load_sum_q;
        ver_sum_d    = ver_sum_q;
        err_code_d   = err_code_q;
        in_ready     = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d      = S_LOAD;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    word_count_d = '0;
                    load_sum_d   = '0;
                    ver_sum_d    = '0;
                    err_code_d   = 2'd0;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                mem_addr = wr_ptr_q;
                if (in_valid) begin
                    mem_we       = 1'b1;
                    mem_wdata    = in_data;
                    word_count_d = word_count_q + WC_ONE;
                    load_sum_d   = load_sum_q ^ in_data;
                    // The pointer never wraps: at the last address it is held,
                    // and the load ends either at the halt or as an overflow.
                    if (wr_ptr_q != WR_MAX) begin
                        wr_ptr_d = wr_ptr_q + WR_ONE;
                    end
                    if (in_data == HALT_WORD) begin
                        state_d = S_VERIFY;
                    end else if (wr_ptr_q == WR_MAX) begin
                        state_d    = S_ERROR;
                        err_code_d = 2'd1;
                    end
                end
            end
            S_VERIFY: begin
                mem_addr  = rd_ptr_q[ADDR_W-1:0];
                ver_sum_d = ver_sum_q ^ mem_rdata;
                rd_ptr_d  = rd_ptr_q + WC_ONE;
                // word_count is at least 1 here since the halt itself counts.
                if (rd_ptr_q == word_count_q - WC_ONE) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (ver_sum_q == load_sum_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_ERROR;
                    err_code_d = 2'd2;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            word_count_q <= '0;
            load_sum_q   <= '0;
            ver_sum_q    <= '0;
            err_code_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            word_count_q <= word_count_d;
            load_sum_q   <= load_sum_d;
            ver_sum_q    <= ver_sum_d;
            err_code_q   <= err_code_d;
        end
    end

    // Status outputs are decoded straight from flops, so they change only
    // on clock edges.
    assign busy       = (state_q == S_LOAD) || (state_q == S_VERIFY);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);
    assign cpu_run    = (state_q == S_DONE);
    assign err_code   = err_code_q;
    assign word_count = word_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [9:0]  in_data = '0;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [9:0]  mem_wdata;
    logic [9:0]  mem_rdata;
    logic        busy, done, error, cpu_run;
    logic [1:0]  err_code;
    logic [10:0] word_count;
    logic [2:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    // expected writes as {addr, data}
    logic [19:0] exp_q[$];
    logic [9:0]  mem [1024];
    logic [9:0]  wv [8];
    logic        force_bad = 1'b0;

    // clock / reset
    always #5 clk = ~clk;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .word_count (word_count),
        .cpu_run    (cpu_run),
        .dbg_state  (dbg_state)
    );

    // instruction memory model with optional corrupted read at addr 2
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = (force_bad && mem_addr == 10'd2) ? 10'h000 : mem[mem_addr];

    // scoreboard monitor: every write strobe must match the next expected write
    always @(negedge clk) begin
        logic [19:0] e;
        if (mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%h (no write expected)", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    failures++;
                    $display("FAIL write addr=%0d data=%h expected addr=%0d data=%h",
                             mem_addr, mem_wdata, e[19:10], e[9:0]);
                end
            end
            checks++;
            if (!in_valid) begin
                failures++;
                $display("FAIL we_without_valid mem_we=1 in_valid=0 expected mem_we=0");
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Pulses start, streams n words (gap idle cycles between words), then
    // waits for done/error. edges counts the start edge as edge 1.
    task automatic run_load(input int n, input int gap, input bit fill,
                            input bit pulse_verify, output int edges);
        logic [9:0] w;
        int t;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); edges = 1; #1 start = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = fill ? 10'h029 : wv[i];
            in_valid = 1'b1;
            in_data  = w;
            exp_q.push_back({10'(i), w});
            @(posedge clk); edges++; #1 in_valid = 1'b0;
            if (i < n - 1) begin
                repeat (gap) begin @(posedge clk); edges++; #1; end
            end
        end
        if (pulse_verify) begin
            start = 1'b1;
            @(posedge clk); edges++; #1 start = 1'b0;
        end
        t = 0;
        while (!done && !error && t < 3000) begin
            @(posedge clk); edges++; #1; t++;
        end
        if (t >= 3000) begin
            checks++; failures++;
            $display("FAIL timeout waiting done/error after %0d cycles expected done or error", t);
        end
    endtask

    task automatic set_normal();
        wv[0] = 10'h029; wv[1] = 10'h012; wv[2] = 10'h2B3; wv[3] = 10'h082;
    endtask

    initial begin
        int e;
        // reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_status", {busy, done, error, cpu_run, in_ready, mem_we}, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_state", dbg_state, 0);

        // normal load
        set_normal();
        run_load(4, 0, 1'b0, 1'b0, e);
        chk("norm_done_edge", e, 10);
        chk("norm_done", done, 1);
        chk("norm_cpu_run", cpu_run, 1);
        chk("norm_err_code", err_code, 0);
        chk("norm_word_count", word_count, 4);
        chk("norm_mem_addr", mem_addr, 0);
        for (int i = 0; i < 4; i++) chk("norm_mem_image", mem[i], wv[i]);
        chk("norm_queue_empty", exp_q.size(), 0);

        // backpressure: 2 idle cycles between words
        for (int i = 0; i < 4; i++) mem[i] = 10'h3FF;
        run_load(4, 2, 1'b0, 1'b0, e);
        chk("bp_done", done, 1);
        chk("bp_word_count", word_count, 4);
        for (int i = 0; i < 4; i++) chk("bp_mem_image", mem[i], wv[i]);
        chk("bp_queue_empty", exp_q.size(), 0);

        // halt first
        wv[0] = 10'h082;
        run_load(1, 0, 1'b0, 1'b0, e);
        chk("halt_done_edge", e, 4);
        chk("halt_done", done, 1);
        chk("halt_word_count", word_count, 1);

        // overflow: 1024 non-halt words
        run_load(1024, 0, 1'b1, 1'b0, e);
        chk("ovf_error", error, 1);
        chk("ovf_err_code", err_code, 1);
        chk("ovf_cpu_run", cpu_run, 0);
        chk("ovf_word_count", word_count, 1024);
        // keep offering words: no further write may appear
        in_valid = 1'b1; in_data = 10'h029;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("ovf_in_ready", in_ready, 0);
        chk("ovf_queue_empty", exp_q.size(), 0);

        // verify mismatch
        set_normal();
        force_bad = 1'b1;
        run_load(4, 0, 1'b0, 1'b0, e);
        force_bad = 1'b0;
        chk("mis_error", error, 1);
        chk("mis_err_code", err_code, 2);
        chk("mis_cpu_run", cpu_run, 0);
        chk("mis_done", done, 0);

        // reset after 2 accepted words
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = wv[i];
            exp_q.push_back({10'(i), wv[i]});
            @(posedge clk); #1 in_valid = 1'b0;
        end
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk("mid_rst_status", {busy, done, error, cpu_run, in_ready, mem_we}, 0);
        chk("mid_rst_bus", {mem_addr, mem_wdata}, 0);
        chk("mid_rst_err_code", err_code, 0);
        chk("mid_rst_word_count", word_count, 0);
        chk("mid_rst_state", dbg_state, 0);

        // restart with halt only, start pulsed during VERIFY
        wv[0] = 10'h082;
        run_load(1, 0, 1'b0, 1'b1, e);
        chk("rs_done_edge", e, 4);
        chk("rs_done", done, 1);
        chk("rs_word_count", word_count, 1);
        chk("rs_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
